dmem_arbiter: RTL and testbench

//  Two-port arbiter and load/store sequencer in front of dmem. Port 0 is the CPU load/store unit;

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dmem_arbiter                                                      |
// | Two-port round-robin arbiter and load/store sequencer in front of dmem,    |
// | with alignment/range checking, byte-lane steering and load extension.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [3:0]  size,
  input  logic [1:0]  uns,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  localparam logic [31:0] c_mem_limit = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_grant;
  logic        r_we;
  logic        r_uns;
  logic [1:0]  r_size;

  logic        w_gnt;
  logic        w_we;
  logic        w_uns;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_bad;
  logic [3:0]  w_dwe;
  logic [31:0] w_dwdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // A lone requester wins outright; a tie goes to the port not served last.
  assign w_gnt   = (req == 2'b10) ? 1'b1 :
                   (req == 2'b01) ? 1'b0 : ~r_last_grant;
  assign w_we    = w_gnt ? we[1]         : we[0];
  assign w_uns   = w_gnt ? uns[1]        : uns[0];
  assign w_size  = w_gnt ? size[3:2]     : size[1:0];
  assign w_addr  = w_gnt ? addr[63:32]   : addr[31:0];
  assign w_wdata = w_gnt ? wdata[63:32]  : wdata[31:0];

  assign w_bad = (w_size == 2'b11)
               | ((w_size == 2'b01) & w_addr[0])
               | ((w_size == 2'b10) & (|w_addr[1:0]))
               | (w_addr >= c_mem_limit);

  always_comb begin
    w_dwe    = 4'b0000;
    w_dwdata = w_wdata;
    case (w_size)
      2'b00: begin
        w_dwe    = 4'b0001 << w_addr[1:0];
        w_dwdata = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_dwe    = 4'b0011 << w_addr[1:0];
        w_dwdata = {2{w_wdata[15:0]}};
      end
      default: begin
        w_dwe    = 4'b1111;
        w_dwdata = w_wdata;
      end
    endcase
    if (!w_we) w_dwe = 4'b0000;
  end

  // daddr still holds the latched address during ACCESS, so its low bits pick the lane.
  assign w_byte = drdata[{daddr[1:0], 3'b000} +: 8];
  assign w_half = drdata[{daddr[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = drdata;
    case (r_size)
      2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ext = drdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'b00;
      ack          <= 2'b00;
      err          <= 1'b0;
      rdata        <= 32'h0;
      daddr        <= 32'h0;
      dwdata       <= 32'h0;
      dwe          <= 4'b0000;
    end else begin
      ack <= 2'b00;
      dwe <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant      <= w_gnt;
            r_last_grant <= w_gnt;
            r_we         <= w_we;
            r_uns        <= w_uns;
            r_size       <= w_size;
            if (w_bad) begin
              r_state <= S_RESP;
              ack     <= w_gnt ? 2'b10 : 2'b01;
              err     <= 1'b1;
              rdata   <= 32'h0;
            end else begin
              r_state <= S_ACCESS;
              err     <= 1'b0;
              daddr   <= w_addr;
              dwdata  <= w_dwdata;
              dwe     <= w_dwe;
            end
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          ack     <= r_grant ? 2'b10 : 2'b01;
          rdata   <= r_we ? 32'h0 : w_ext;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_dmem_arbiter                                                   |
// | Scoreboard bench for dmem_arbiter with a byte-addressed dmem model.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [3:0]  size;
  logic [1:0]  uns;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  dwe;
    logic [31:0] dwdata;
    logic        chk_dd;
  } exp_t;

  exp_t sbq[$];

  logic [31:0] mem [32];
  logic [3:0]  seen_dwe;
  logic [31:0] seen_dwdata;

  dmem_arbiter #(.MEM_BYTES(128)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .size   (size),
    .uns    (uns),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dwe    (dwe),
    .drdata (drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem: combinational word read, byte-enabled write on the clock edge
  assign drdata = mem[daddr[6:2]];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dwe[i]) mem[daddr[6:2]][8*i +: 8] <= dwdata[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: remembers the store strobe of the current access, scores each ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_dwe    = 4'b0000;
      seen_dwdata = 32'h0;
    end else begin
      if (dwe != 4'b0000) begin
        seen_dwe    = dwe;
        seen_dwdata = dwdata;
      end
      if (ack != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", {30'h0, ack}, 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_port", {30'h0, ack}, e.port ? 32'h2 : 32'h1);
          chk("err", {31'h0, err}, {31'h0, e.err});
          if (!e.err) chk("rdata", rdata, e.rdata);
          chk("dwe", {28'h0, seen_dwe}, {28'h0, e.dwe});
          if (e.chk_dd) chk("dwdata", seen_dwdata, e.dwdata);
        end
        seen_dwe    = 4'b0000;
        seen_dwdata = 32'h0;
      end
    end
  end

  task automatic drive(input int p, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    we[p]           = w;
    uns[p]          = u;
    size[2*p +: 2]  = sz;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
  endtask

  task automatic access(input int p, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                        input logic e_err, input logic [31:0] e_rd, input logic [3:0] e_dwe,
                        input logic [31:0] e_dd);
    exp_t e;
    int   n;
    e.port = p[0]; e.err = e_err; e.rdata = e_rd; e.dwe = e_dwe;
    e.dwdata = e_dd; e.chk_dd = (e_dwe != 4'b0000);
    sbq.push_back(e);
    @(negedge clk);
    drive(p, w, sz, u, a, d);
    req[p] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack[p] && n < 10);
    chk("latency", n, exp_lat);
    @(negedge clk);
    req[p] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int n, acks;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    seen_dwe = 4'b0000; seen_dwdata = 32'h0;
    rst_n = 1'b0; req = 2'b00; we = 2'b00; size = 4'h0; uns = 2'b00;
    addr = 64'h0; wdata = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {30'h0, ack}, 32'h0);
    chk("rst_outs", {err, dwe} | rdata | daddr | dwdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Tie straight after reset: strict 0,1,0,1 alternation, one access per 3 cycles
    sbq.push_back('{1'b0, 1'b0, 32'h0, 4'hF, 32'hAAAA0000, 1'b1});
    sbq.push_back('{1'b1, 1'b0, 32'h0, 4'hF, 32'h0000BBBB, 1'b1});
    sbq.push_back('{1'b0, 1'b0, 32'h0, 4'hF, 32'hAAAA0000, 1'b1});
    sbq.push_back('{1'b1, 1'b0, 32'h0, 4'hF, 32'h0000BBBB, 1'b1});
    @(negedge clk);
    drive(0, 1'b1, 2'b10, 1'b0, 32'h00, 32'hAAAA0000);
    drive(1, 1'b1, 2'b10, 1'b0, 32'h04, 32'h0000BBBB);
    req = 2'b11;
    n = 0; acks = 0;
    while (acks < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack != 2'b00) acks++;
    end
    chk("tie_cycles", n, 11);
    @(negedge clk); req = 2'b00;
    @(posedge clk);

    // Word store / load
    access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0);
    // Byte store replicated from the low byte only, then extended loads
    access(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5, 2, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5);
    access(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFA5, 4'b0000, 32'h0);
    access(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'h000000A5, 4'b0000, 32'h0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hA5ADBEEF, 4'b0000, 32'h0);
    // Half store in the upper lanes, then half and byte loads
    access(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h55558234, 2, 1'b0, 32'h0, 4'b1100, 32'h82348234);
    access(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 2, 1'b0, 32'hFFFF8234, 4'b0000, 32'h0);
    access(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 2, 1'b0, 32'h00008234, 4'b0000, 32'h0);
    access(1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 2, 1'b0, 32'hFFFFFF82, 4'b0000, 32'h0);
    access(1, 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 2, 1'b0, 32'h00000034, 4'b0000, 32'h0);
    // Errors: misaligned half, out of range, reserved size; memory must not change
    access(0, 1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 4'b0000, 32'h0);
    access(1, 1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 4'b0000, 32'h0);
    access(0, 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 4'b0000, 32'h0);
    access(0, 1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 4'b0000, 32'h0);
    access(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 2, 1'b0, 32'hAAAA0000, 4'b0000, 32'h0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 2, 1'b0, 32'h00000000, 4'b0000, 32'h0);

    // Reset during the ACCESS of a store
    access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 2, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D);
    @(negedge clk);
    drive(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    req[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_dwe_before", {28'h0, dwe}, 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_dwe_after", {28'h0, dwe}, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_ack", {30'h0, ack}, 32'h0);
    req[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'hCAFEF00D, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
